ab_logic_stream: RTL and testbench

//   Streaming, parametrised bitwise logic unit for the A/B gate family.
//   - Per transaction: two WIDTH-bit operands and a 2-bit opcode selecting the function.
//   - Two-stage elastic pipeline with valid/ready on both sides.
//   - Stage 1 evaluates the function; stage 2 adds a popcount of the result.
//   - Sits between an operand source and any ready/valid consumer.

---
 rtl/ab_logic_stream.sv | 88 ++++++++
 tb/tb_ab_logic_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ab_logic_stream.sv
// Two-stage elastic bitwise logic unit (x|~y, x&~y, ~(x^y), x^y) with popcount of the result.
// Optional AB_STATS_EN adds a saturating output-handshake counter with synchronous clear.
module ab_logic_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int ONES_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_z,
    output logic [ONES_W-1:0] out_ones
`ifdef AB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  stats_cnt
`endif
);

    logic             s1_valid, s2_valid;
    logic             s1_en, s2_en;
    logic [WIDTH-1:0] s1_z, f_z;
    logic [ONES_W-1:0] ones_nxt;

    // in_ready follows out_ready combinationally so a full pipe still moves one beat per cycle
    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    always_comb begin
        f_z = '0;
        case (in_op)
            2'b00:   f_z = in_x | ~in_y;
            2'b01:   f_z = in_x & ~in_y;
            2'b10:   f_z = ~(in_x ^ in_y);
            default: f_z = in_x ^ in_y;
        endcase
    end

    always_comb begin
        ones_nxt = '0;
        for (int i = 0; i < WIDTH; i++)
            ones_nxt = ones_nxt + ONES_W'(s1_z[i]);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            s1_valid <= 1'b0;
            s1_z     <= '0;
            s2_valid <= 1'b0;
            out_z    <= '0;
            out_ones <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid)
                    s1_z <= f_z;
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                out_z    <= s1_z;
                out_ones <= ones_nxt;
            end
        end
    end

`ifdef AB_STATS_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            stats_cnt <= '0;
        else if (stats_clr)
            stats_cnt <= '0;
        else if (out_valid && out_ready && (stats_cnt != {CNT_W{1'b1}}))
            stats_cnt <= stats_cnt + 1'b1;
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_ab_logic_stream.sv
// Directed self-checking bench for ab_logic_stream (WIDTH=8; stats checks when AB_STATS_EN is defined).
module tb_ab_logic_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             areset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_x = '0;
    logic [WIDTH-1:0] in_y = '0;
    logic [1:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_z;
    logic [3:0]       out_ones;
`ifdef AB_STATS_EN
    logic             stats_clr = 1'b0;
    logic [CNT_W-1:0] stats_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ab_logic_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_ones  (out_ones)
`ifdef AB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .stats_cnt (stats_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
        in_valid = v;
        in_x     = x;
        in_y     = y;
        in_op    = op;
    endtask

    function automatic logic [7:0] ref_f(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
        case (op)
            2'b00:   return x | ~y;
            2'b01:   return x & ~y;
            2'b10:   return ~(x ^ y);
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic [3:0] ref_ones(input logic [7:0] z);
        logic [3:0] c = '0;
        for (int i = 0; i < 8; i++) c = c + 4'(z[i]);
        return c;
    endfunction

    logic [7:0] exp_z [10];
    logic [7:0] t1_z    [4] = '{8'hF3, 8'h30, 8'hC3, 8'h3C};
    logic [3:0] t1_ones [4] = '{4'd6, 4'd2, 4'd4, 4'd4};

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_z", 32'(out_z), 0);
        chk("rst_out_ones", 32'(out_ones), 0);
`ifdef AB_STATS_EN
        chk("rst_stats", 32'(stats_cnt), 0);
`endif
        @(negedge clk);
        areset = 1'b0;
        step();

        // four functions back to back, x=F0 y=CC
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b1, 8'hF0, 8'hCC, 2'(k));
            else       drive(1'b0, 8'h00, 8'h00, 2'b00);
            step();
            if (k == 0) chk("t1_latency", 32'(out_valid), 0);
            else if (k <= 4) begin
                chk("t1_valid", 32'(out_valid), 1);
                chk("t1_z", 32'(out_z), 32'(t1_z[k-1]));
                chk("t1_ones", 32'(out_ones), 32'(t1_ones[k-1]));
            end
        end
        chk("t1_drained", 32'(out_valid), 0);

`ifdef AB_STATS_EN
        // saturating counter, CNT_W=2
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("st_clr", 32'(stats_cnt), 0);
        for (int k = 0; k < 7; k++) begin
            if (k < 5) drive(1'b1, 8'hAA, 8'h55, 2'b11);
            else       drive(1'b0, 8'h00, 8'h00, 2'b00);
            step();
            if (k >= 2) chk("st_cnt", 32'(stats_cnt), (k == 2) ? 1 : (k == 3) ? 2 : 3);
        end
        drive(1'b1, 8'h01, 8'h00, 2'b11);
        step();
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        step();
        chk("st_pre_clr_valid", 32'(out_valid), 1);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("st_clr_prio", 32'(stats_cnt), 0);
        step();
`endif

        // backpressure: 3 beats with out_ready=0, then hold and drain
        out_ready = 1'b0;
        drive(1'b1, 8'hFF, 8'h00, 2'b11);
        chk("t2_rdy_a", 32'(in_ready), 1);
        step();
        drive(1'b1, 8'h0F, 8'h00, 2'b11);
        chk("t2_rdy_b", 32'(in_ready), 1);
        step();
        drive(1'b1, 8'h01, 8'h00, 2'b11);
        chk("t2_full", 32'(in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_hold_valid", 32'(out_valid), 1);
            chk("t2_hold_z", 32'(out_z), 32'h00FF);
            chk("t2_hold_ones", 32'(out_ones), 8);
            chk("t2_hold_rdy", 32'(in_ready), 0);
`ifdef AB_STATS_EN
            chk("t2_hold_stats", 32'(stats_cnt), 0);
`endif
        end
        out_ready = 1'b1;
        #1;
        chk("t2_comb_rdy", 32'(in_ready), 1);
        step();
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        chk("t2_z_b", 32'(out_z), 32'h0F);
        chk("t2_ones_b", 32'(out_ones), 4);
        step();
        chk("t2_z_c", 32'(out_z), 32'h01);
        chk("t2_ones_c", 32'(out_ones), 1);
        step();
        chk("t2_empty", 32'(out_valid), 0);

        // full-rate streaming, 10 beats
        for (int k = 0; k < 11; k++) begin
            if (k < 10) begin
                drive(1'b1, 8'(k * 37), 8'(k * 11 + 5), 2'(k % 4));
                exp_z[k] = ref_f(in_x, in_y, in_op);
            end else begin
                drive(1'b0, 8'h00, 8'h00, 2'b00);
            end
            chk("t3_rdy", 32'(in_ready), 1);
            step();
            if (k >= 1) begin
                chk("t3_valid", 32'(out_valid), 1);
                chk("t3_z", 32'(out_z), 32'(exp_z[k-1]));
                chk("t3_ones", 32'(out_ones), 32'(ref_ones(exp_z[k-1])));
            end
        end
        step();

        // async reset with two beats in flight
        out_ready = 1'b0;
        drive(1'b1, 8'h3C, 8'h00, 2'b11);
        step();
        step();
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        chk("t4_pre_valid", 32'(out_valid), 1);
        #2 areset = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(out_valid), 0);
        chk("t4_rst_rdy", 32'(in_ready), 1);
        chk("t4_rst_z", 32'(out_z), 0);
        step();
        areset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_no_stale", 32'(out_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
